spu_issue_queue: RTL

//  In-order issue queue feeding the special-purpose unit (CP0/TLB/trap/ERET/CACHE ops).

---
 rtl/spu_issue_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spu_issue_queue.sv
// spu_issue_queue: in-order issue queue for special-purpose ops (CP0/TLB/trap/ERET/CACHE).
// Latency: enqueue->issue 1 cycle when sources are ready and the op is at the ROB head; wakeup at t -> eligible at t+1.
// Backpressure: spu_iq_allowin drops when full; a same-cycle issue does not free a slot for dispatch.
// Optional feature macro: SPU_IQ_PERF_EN (adds the stall_cycles counter and port).

package spu_iq_pkg;
  localparam int PHY_W = 6;
  localparam int ROB_W = 4;

  typedef struct packed {
    logic [7:0]  operation;
    logic [7:0]  cp0_addr;
    logic [15:0] imm;
  } decoded_inst_t;

  typedef struct packed {
    decoded_inst_t     inst;
    logic [31:0]       src1_value;
    logic [31:0]       src2_value;
    logic [PHY_W-1:0]  phy_dest;
    logic [ROB_W-1:0]  rob_entry_num;
  } issue_to_execute_bus_t;
endpackage

module spu_issue_queue
  import spu_iq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_WB = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      dispatch_valid,
  output logic                      spu_iq_allowin,
  input  decoded_inst_t             dispatch_inst,
  input  logic [PHY_W-1:0]          dispatch_phy_src1,
  input  logic [PHY_W-1:0]          dispatch_phy_src2,
  input  logic                      dispatch_src1_ready,
  input  logic                      dispatch_src2_ready,
  input  logic [PHY_W-1:0]          dispatch_phy_dest,
  input  logic [ROB_W-1:0]          dispatch_rob_entry,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*PHY_W-1:0]   wb_tag,
  input  logic [ROB_W-1:0]          rob_head,
  output logic [PHY_W-1:0]          prf_raddr1,
  output logic [PHY_W-1:0]          prf_raddr2,
  input  logic [31:0]               prf_rdata1,
  input  logic [31:0]               prf_rdata2,
  output logic                      issue_to_spu_valid,
  output issue_to_execute_bus_t     issue_inst
`ifdef SPU_IQ_PERF_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-slot entry state
  logic                r_vld  [DEPTH];
  decoded_inst_t       r_inst [DEPTH];
  logic [PHY_W-1:0]    r_src1 [DEPTH];
  logic [PHY_W-1:0]    r_src2 [DEPTH];
  logic                r_rdy1 [DEPTH];
  logic                r_rdy2 [DEPTH];
  logic [PHY_W-1:0]    r_dest [DEPTH];
  logic [ROB_W-1:0]    r_rob  [DEPTH];

  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  logic                w_full;
  logic                w_nonempty;
  logic                w_enq;
  logic                w_issue;

  // True when any valid writeback port broadcasts the given tag this cycle
  function automatic logic f_wake(input logic [PHY_W-1:0]        tag,
                                  input logic [NUM_WB-1:0]       vld,
                                  input logic [NUM_WB*PHY_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (vld[k] && (tags[k*PHY_W +: PHY_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Occupancy, dispatch acceptance and head-only issue decision
  always_comb begin
    w_full             = (r_count == CNT_W'(DEPTH));
    w_nonempty         = (r_count != '0);
    spu_iq_allowin     = !w_full;
    w_enq              = dispatch_valid && !w_full && !flush;
    w_issue            = !flush && w_nonempty && r_rdy1[r_head] && r_rdy2[r_head]
                         && (r_rob[r_head] == rob_head);
    issue_to_spu_valid = w_issue;
  end

  // Head operand read and issue bus assembly; regfile data passes straight through
  always_comb begin
    prf_raddr1               = r_src1[r_head];
    prf_raddr2               = r_src2[r_head];
    issue_inst               = '0;
    issue_inst.inst          = r_inst[r_head];
    issue_inst.src1_value    = prf_rdata1;
    issue_inst.src2_value    = prf_rdata2;
    issue_inst.phy_dest      = r_dest[r_head];
    issue_inst.rob_entry_num = r_rob[r_head];
  end

  // Queue state: reset/flush clear everything; otherwise wakeup, enqueue at tail, pop at head
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_rdy1[i] <= 1'b0;
        r_rdy2[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i]) begin
          r_rdy1[i] <= r_rdy1[i] | f_wake(r_src1[i], wb_valid, wb_tag);
          r_rdy2[i] <= r_rdy2[i] | f_wake(r_src2[i], wb_valid, wb_tag);
        end
      end
      // The tail slot is never the issuing head: issue needs count!=0 and enqueue needs count!=DEPTH
      if (w_enq) begin
        r_vld[r_tail]  <= 1'b1;
        r_inst[r_tail] <= dispatch_inst;
        r_src1[r_tail] <= dispatch_phy_src1;
        r_src2[r_tail] <= dispatch_phy_src2;
        r_rdy1[r_tail] <= dispatch_src1_ready || (dispatch_phy_src1 == '0)
                          || f_wake(dispatch_phy_src1, wb_valid, wb_tag);
        r_rdy2[r_tail] <= dispatch_src2_ready || (dispatch_phy_src2 == '0)
                          || f_wake(dispatch_phy_src2, wb_valid, wb_tag);
        r_dest[r_tail] <= dispatch_phy_dest;
        r_rob[r_tail]  <= dispatch_rob_entry;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_issue) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SPU_IQ_PERF_EN
  logic [31:0] r_stall_cycles;

  // Count cycles with work queued but nothing issued; survives flush, saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_nonempty && !w_issue && !flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
